// File: rtl/mem_phase_unit.sv
// Memory-phase unit: one data-memory access per instruction over a req/ack bus,
// with load formatting for writeback and sticky fault reporting.
module mem_phase_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_stall,
    input  logic              reg_write_stall,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t            state;
    logic              prev_stall;
    logic              win_start;
    logic              access;
    logic              misaligned;
    logic              timeout_hit;

    logic              l_rd;
    logic              l_wr;
    logic              l_uns;
    logic [1:0]        l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic [CW-1:0]     wait_cnt;

    logic [1:0]        lane;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       rdata_fmt;
    logic [3:0]        be_raw;
    logic [31:0]       wdata_rep;

    assign win_start   = ~mem_stall & prev_stall;
    assign access      = mem_read | mem_write;
    assign lane        = l_addr[1:0];
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane select and extension of the returned word.
    always_comb begin
        lane_byte = bus_rdata[{lane, 3'b000} +: 8];
        lane_half = bus_rdata[{lane[1], 4'b0000} +: 16];
        unique case (l_size)
            2'b00:   rdata_fmt = {{24{~l_uns & lane_byte[7]}}, lane_byte};
            2'b01:   rdata_fmt = {{16{~l_uns & lane_half[15]}}, lane_half};
            default: rdata_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        unique case (l_size)
            2'b00: begin
                be_raw    = 4'b0001 << lane;
                wdata_rep = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << lane;
                wdata_rep = {2{l_wdata[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_rep = l_wdata;
            end
        endcase
    end

    assign bus_req    = (state == REQ);
    assign bus_we     = bus_req & l_wr & ~l_rd;
    assign bus_addr   = bus_req ? {l_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be     = bus_req ? be_raw : 4'b0000;
    assign bus_wdata  = bus_req ? wdata_rep : 32'h0;
    assign load_valid = (state == DONE) & l_rd & ~reg_write_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_stall <= 1'b1;
            l_rd       <= 1'b0;
            l_wr       <= 1'b0;
            l_uns      <= 1'b0;
            l_size     <= 2'b00;
            l_addr     <= '0;
            l_wdata    <= 32'h0;
            wait_cnt   <= '0;
            load_data  <= 32'h0;
            fault      <= 1'b0;
        end else begin
            prev_stall <= mem_stall;
            if (win_start) begin
                l_rd    <= mem_read;
                l_wr    <= mem_write;
                l_uns   <= is_unsigned;
                l_size  <= size;
                l_addr  <= addr;
                l_wdata <= wdata;
            end
            // A closing window abandons whatever is in progress.
            if (mem_stall) begin
                state    <= IDLE;
                wait_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        wait_cnt <= '0;
                        if (win_start && access) begin
                            if (misaligned) begin
                                state <= ERR;
                                fault <= 1'b1;
                            end else begin
                                state <= REQ;
                            end
                        end
                    end
                    REQ: begin
                        if (!reg_write_stall) begin
                            state <= ERR;
                            fault <= 1'b1;
                        end else if (bus_ack) begin
                            state <= DONE;
                            if (l_rd) load_data <= rdata_fmt;
                        end else if (timeout_hit) begin
                            state <= ERR;
                            fault <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (!reg_write_stall) state <= IDLE;
                    end
                    ERR: begin
                        if (!reg_write_stall) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_phase_unit.sv
// Bench for mem_phase_unit: 3-cycle windows driven from a transaction-level
// model, with a per-cycle compare process plus hand-computed checks.
module tb_mem_phase_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_stall = 1'b1;
    logic        reg_write_stall = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        is_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;

    mem_phase_unit #(.ADDR_W(32), .TIMEOUT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_stall(mem_stall), .reg_write_stall(reg_write_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .is_unsigned(is_unsigned),
        .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .load_data(load_data), .load_valid(load_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [31:0] ld_m;
    bit          fault_m;

    logic        exp_req, exp_we, exp_lv, exp_fault;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;

    int          req_cnt, lv_cnt;
    logic        w1_we, w1_fault, w2_lv, w2_fault;
    logic [3:0]  w1_be;
    logic [31:0] w1_wdata, w2_ld;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit bad_access(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] fmt(input logic [1:0] sz, input bit uns,
                                        input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 3 : 15;
        if (sz < 2'd2) n = n << a[1:0];
        return n[3:0];
    endfunction

    function automatic logic [31:0] rep(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    task automatic set_idle_exp();
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = 32'h0;
        exp_be    = 4'h0;
        exp_wdata = 32'h0;
        exp_lv    = 1'b0;
        exp_ld    = ld_m;
        exp_fault = fault_m;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_req", bus_req, exp_req);
            check("bus_we", bus_we, exp_we);
            check("bus_addr", bus_addr, exp_addr);
            check("bus_be", bus_be, exp_be);
            check("bus_wdata", bus_wdata, exp_wdata);
            check("load_valid", load_valid, exp_lv);
            check("load_data", load_data, exp_ld);
            check("fault", fault, exp_fault);
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
        req_cnt += bus_req;
        lv_cnt  += load_valid;
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        ld_m            = 32'h0;
        fault_m         = 1'b0;
        mem_stall       = 1'b1;
        reg_write_stall = 1'b1;
        bus_ack         = 1'b0;
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_win(input bit rd, input bit wr, input logic [1:0] sz,
                           input bit uns, input logic [31:0] a,
                           input logic [31:0] w, input bit ack,
                           input logic [31:0] rdata, input int gap,
                           input bit rst_w1);
        bit acc, go;
        acc = rd | wr;
        go  = acc && !bad_access(sz, a);
        req_cnt = 0;
        lv_cnt  = 0;
        repeat (gap) begin
            @(posedge clk); #1;
            mem_stall       = 1'b1;
            reg_write_stall = 1'b1;
            mem_read        = 1'($urandom);
            mem_write       = 1'($urandom);
            bus_ack         = 1'($urandom);
            bus_rdata       = $urandom;
            set_idle_exp();
            sample();
        end
        @(posedge clk); #1;
        mem_stall       = 1'b0;
        reg_write_stall = 1'b1;
        mem_read        = rd;
        mem_write       = wr;
        size            = sz;
        is_unsigned     = uns;
        addr            = a;
        wdata           = w;
        bus_ack         = 1'($urandom);
        bus_rdata       = $urandom;
        set_idle_exp();
        sample();
        @(posedge clk); #1;
        if (acc && !go) fault_m = 1'b1;
        mem_read    = 1'($urandom);
        mem_write   = 1'($urandom);
        size        = 2'($urandom);
        is_unsigned = 1'($urandom);
        addr        = $urandom;
        wdata       = $urandom;
        bus_ack     = ack;
        bus_rdata   = rdata;
        set_idle_exp();
        if (go) begin
            exp_req   = 1'b1;
            exp_we    = wr && !rd;
            exp_addr  = a & 32'hFFFFFFFC;
            exp_be    = be_of(sz, a);
            exp_wdata = rep(sz, w);
        end
        sample();
        w1_be    = bus_be;
        w1_we    = bus_we;
        w1_wdata = bus_wdata;
        w1_fault = fault;
        if (rst_w1) begin
            apply_reset_mid();
            return;
        end
        @(posedge clk); #1;
        if (go) begin
            if (ack) begin
                if (rd) ld_m = fmt(sz, uns, a, rdata);
            end else begin
                fault_m = 1'b1;
            end
        end
        reg_write_stall = 1'b0;
        bus_ack         = 1'($urandom);
        bus_rdata       = $urandom;
        set_idle_exp();
        exp_lv = go && ack && rd;
        sample();
        w2_ld    = load_data;
        w2_lv    = load_valid;
        w2_fault = fault;
    endtask

    task automatic apply_reset_mid();
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req_drops", bus_req, 1'b0);
        apply_reset();
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        ld_m    = 32'h0;
        fault_m = 1'b0;
        set_idle_exp();
        #1;
        rst_n  = 1'b0;
        chk_en = 1'b1;
        #2;
        check("rst_req", bus_req, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_ld", load_data, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_win(1, 0, 2'd2, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 2, 0);
        check("t1_be", w1_be, 4'b1111);
        check("t1_ld", w2_ld, 32'hDEADBEEF);
        check("t1_lv_w2", w2_lv, 1'b1);
        check("t1_lv_cnt", lv_cnt, 1);

        check("t2_model", fmt(2'd0, 0, 32'h103, 32'h80FFFFFF), 32'hFFFFFF80);
        run_win(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 32'h80FFFFFF, 1, 0);
        check("t2_be", w1_be, 4'b1000);
        check("t2_lb", w2_ld, 32'hFFFFFF80);
        run_win(1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 32'h80FFFFFF, 1, 0);
        check("t2_lbu", w2_ld, 32'h00000080);

        check("t3_model", rep(2'd1, 32'h1234ABCD), 32'hABCDABCD);
        run_win(0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 1, $urandom, 1, 0);
        check("t3_we", w1_we, 1'b1);
        check("t3_be", w1_be, 4'b1100);
        check("t3_wdata", w1_wdata, 32'hABCDABCD);
        check("t3_lv_cnt", lv_cnt, 0);
        check("t3_ld_held", w2_ld, 32'h00000080);

        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            run_win(1'($urandom), 1'($urandom), sz, 1'($urandom), a, $urandom,
                    1, $urandom, $urandom_range(1, 3), 0);
        end
        check("legal_no_fault", fault, 1'b0);

        run_win(1, 0, 2'd2, 0, 32'h200, 32'h0, 0, $urandom, 1, 1);
        check("t6_req_before", req_cnt, 1);
        run_win(1, 0, 2'd2, 0, 32'h204, 32'h0, 1, 32'hCAFEF00D, 1, 0);
        check("t6_after_ld", w2_ld, 32'hCAFEF00D);
        check("t6_after_lv", w2_lv, 1'b1);

        run_win(1, 0, 2'd2, 0, 32'h101, 32'h0, 1, $urandom, 1, 0);
        check("t4_no_req", req_cnt, 0);
        check("t4_fault_w1", w1_fault, 1'b1);
        check("t4_lv_cnt", lv_cnt, 0);
        run_win(1, 0, 2'd2, 0, 32'h108, 32'h0, 1, 32'h13572468, 1, 0);
        check("t4_sticky", w2_fault, 1'b1);
        check("t4_next_ld", w2_ld, 32'h13572468);
        apply_reset();
        check("t4_reset_clears", fault, 1'b0);

        run_win(1, 0, 2'd2, 0, 32'h300, 32'h0, 0, $urandom, 1, 0);
        check("t5_req_cnt", req_cnt, 1);
        check("t5_lv_cnt", lv_cnt, 0);
        check("t5_fault", w2_fault, 1'b1);
        apply_reset();

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_win(1'($urandom), 1'($urandom), sz, 1'($urandom), a, $urandom,
                    ($urandom_range(0, 3) != 0), $urandom, $urandom_range(1, 3), 0);
            if (i == 100) apply_reset();
        end

        @(posedge clk); #1;
        mem_stall       = 1'b1;
        reg_write_stall = 1'b1;
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
